// File: rtl/vtimgen.sv
// vtimgen: register-programmable video timing generator with
// interlaced half-line vsync and frame-boundary register reload.
module vtimgen #(
    parameter int HW       = 10,
    parameter int VW       = 10,
    parameter int H_LAST   = 511,
    parameter int V_LAST   = 312,
    parameter int HS_START = 470,
    parameter int HS_END   = 510,
    parameter int HD_START = 56,
    parameter int HD_END   = 376,
    parameter int HB_START = 440,
    parameter int HB_END   = 512,
    parameter int VS_START = 0,
    parameter int VS_END   = 3,
    parameter int VD_START = 63,
    parameter int VD_END   = 263,
    parameter int VB_START = 0,
    parameter int VB_END   = 25
) (
    input  logic          clk,
    input  logic          resb,
    input  logic          pix_en,
    input  logic          interlace,
    input  logic          wr,
    input  logic [3:0]    waddr,
    input  logic [15:0]   wdata,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          de,
    output logic          blank_n,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          field,
    output logic          frame_start
);

    localparam logic [HW-1:0] H_DEF [7] = '{
        HW'(H_LAST), HW'(HS_START), HW'(HS_END), HW'(HD_START),
        HW'(HD_END), HW'(HB_START), HW'(HB_END)
    };
    localparam logic [VW-1:0] V_DEF [7] = '{
        VW'(V_LAST), VW'(VS_START), VW'(VS_END), VW'(VD_START),
        VW'(VD_END), VW'(VB_START), VW'(VB_END)
    };

    // index 0 is the last count, then start/end pairs for sync, DE, blank
    logic [HW-1:0] h_sh [7];
    logic [HW-1:0] h_ac [7];
    logic [VW-1:0] v_sh [7];
    logic [VW-1:0] v_ac [7];

    logic          ilace_act;
    logic [VW-1:0] v_lim;
    logic [HW-1:0] off;
    logic [3:0]    vidx;
    logic          line_end;
    logic          wrap;
    logic          vs_go;
    logic          vs_stop;
    logic          unused;

    function automatic logic hwin(input logic [HW-1:0] c,
                                  input logic [HW-1:0] s,
                                  input logic [HW-1:0] e);
        return (c >= s) && (c < e);
    endfunction

    function automatic logic vwin(input logic [VW-1:0] c,
                                  input logic [VW-1:0] s,
                                  input logic [VW-1:0] e);
        return (c >= s) && (c < e);
    endfunction

    assign vidx   = waddr - 4'd7;
    assign unused = ^{wdata, vidx[3]};

    always_comb begin
        v_lim    = v_ac[0] + VW'(ilace_act & field);
        line_end = (hcnt == h_ac[0]);
        wrap     = pix_en && line_end && (vcnt == v_lim);
        off      = '0;
        if (field && ilace_act)
            off = {1'b0, h_ac[0][HW-1:1]} + HW'(1);
        // vsync edges are (line, pixel) points so odd fields can start mid-line
        vs_go   = (vcnt > v_ac[1]) || ((vcnt == v_ac[1]) && (hcnt >= off));
        vs_stop = (vcnt > v_ac[2]) || ((vcnt == v_ac[2]) && (hcnt >= off));
    end

    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            for (int i = 0; i < 7; i++) begin
                h_sh[i] <= H_DEF[i];
                h_ac[i] <= H_DEF[i];
                v_sh[i] <= V_DEF[i];
                v_ac[i] <= V_DEF[i];
            end
        end else begin
            if (wrap) begin
                h_ac <= h_sh;
                v_ac <= v_sh;
            end
            if (wr && (waddr < 4'd7))
                h_sh[waddr[2:0]] <= wdata[HW-1:0];
            else if (wr && (waddr < 4'd14))
                v_sh[vidx[2:0]] <= wdata[VW-1:0];
        end
    end

    always_ff @(posedge clk or negedge resb) begin
        if (!resb) begin
            hcnt        <= '0;
            vcnt        <= '0;
            field       <= 1'b0;
            ilace_act   <= 1'b0;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            de          <= 1'b0;
            blank_n     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
            if (pix_en) begin
                hsync_n <= ~hwin(hcnt, h_ac[1], h_ac[2]);
                vsync_n <= ~(vs_go && !vs_stop);
                de      <= hwin(hcnt, h_ac[3], h_ac[4])
                         & vwin(vcnt, v_ac[3], v_ac[4]);
                blank_n <= ~(hwin(hcnt, h_ac[5], h_ac[6])
                           | vwin(vcnt, v_ac[5], v_ac[6]));
                if (line_end) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == v_lim) ? '0 : vcnt + VW'(1);
                end else begin
                    hcnt <= hcnt + HW'(1);
                end
            end
            if (wrap) begin
                field     <= interlace & ~field;
                ilace_act <= interlace;
            end
        end
    end

endmodule

// File: tb/tb_vtimgen.sv
// tb_vtimgen: directed-vector bench for vtimgen, using a small-frame
// instance (16x8) plus a default-parameter instance.
module tb_vtimgen;

    logic       clk = 1'b0;
    logic       resb;
    logic       pix_en;
    logic       interlace;
    logic       wr;
    logic [3:0] waddr;
    logic [15:0] wdata;

    logic       hsync_n, vsync_n, de, blank_n, field, frame_start;
    logic [9:0] hcnt, vcnt;
    logic       d_hsync_n, d_vsync_n, d_de, d_blank_n, d_field, d_fs;
    logic [9:0] d_hcnt, d_vcnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vtimgen #(
        .H_LAST(15), .V_LAST(7),
        .HS_START(12), .HS_END(15),
        .HD_START(2), .HD_END(10),
        .HB_START(11), .HB_END(16),
        .VS_START(0), .VS_END(2),
        .VD_START(2), .VD_END(6),
        .VB_START(0), .VB_END(1)
    ) u_dut (
        .clk(clk), .resb(resb), .pix_en(pix_en), .interlace(interlace),
        .wr(wr), .waddr(waddr), .wdata(wdata),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .de(de), .blank_n(blank_n),
        .hcnt(hcnt), .vcnt(vcnt), .field(field), .frame_start(frame_start)
    );

    vtimgen u_def (
        .clk(clk), .resb(resb), .pix_en(pix_en), .interlace(interlace),
        .wr(1'b0), .waddr(4'd0), .wdata(16'd0),
        .hsync_n(d_hsync_n), .vsync_n(d_vsync_n), .de(d_de),
        .blank_n(d_blank_n), .hcnt(d_hcnt), .vcnt(d_vcnt),
        .field(d_field), .frame_start(d_fs)
    );

    typedef struct {
        int n;
        int h;
        int v;
        bit hs;
        bit vs;
        bit de;
        bit bn;
        bit fs;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wreg(input int a, input int d);
        wr    = 1'b1;
        waddr = a[3:0];
        wdata = d[15:0];
        step();
        wr    = 1'b0;
    endtask

    task automatic wait_fs(input int max, output int n);
        n = 0;
        while (n < max) begin
            step();
            n++;
            if (frame_start) break;
        end
        if (!frame_start) begin
            checks++;
            errors++;
            $display("FAIL wait_fs: no frame_start within %0d clks", n);
        end
    endtask

    task automatic wait_hv(input int h, input int v, input int max,
                           output int n);
        n = 0;
        while (n < max) begin
            step();
            n++;
            if (hcnt == h[9:0] && vcnt == v[9:0]) break;
        end
        if (!(hcnt == h[9:0] && vcnt == v[9:0])) begin
            checks++;
            errors++;
            $display("FAIL wait_hv: (%0d,%0d) not reached in %0d clks",
                     h, v, n);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_hcnt"}, hcnt, 0);
        chk({nm, "_vcnt"}, vcnt, 0);
        chk({nm, "_hs"}, hsync_n, 1);
        chk({nm, "_vs"}, vsync_n, 1);
        chk({nm, "_de"}, de, 0);
        chk({nm, "_bn"}, blank_n, 0);
        chk({nm, "_field"}, field, 0);
        chk({nm, "_fs"}, frame_start, 0);
        chk({nm, "_def_vs"}, d_vsync_n, 1);
        chk({nm, "_def_bn"}, d_blank_n, 0);
    endtask

    initial begin
        int edges;
        int n;
        int c1;
        int en;
        int z0;
        int z1;
        bit exp_hs;
        int p;

        // n edges after release; outputs describe position n-1
        tbl[0]  = '{1,   1,  0, 1, 0, 0, 0, 0};
        tbl[1]  = '{13,  13, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{16,  0,  1, 1, 0, 0, 0, 0};
        tbl[3]  = '{35,  3,  2, 1, 1, 1, 1, 0};
        tbl[4]  = '{42,  10, 2, 1, 1, 1, 1, 0};
        tbl[5]  = '{43,  11, 2, 1, 1, 0, 1, 0};
        tbl[6]  = '{44,  12, 2, 1, 1, 0, 0, 0};
        tbl[7]  = '{45,  13, 2, 0, 1, 0, 0, 0};
        tbl[8]  = '{99,  3,  6, 1, 1, 0, 1, 0};
        tbl[9]  = '{112, 0,  7, 1, 1, 0, 0, 0};
        tbl[10] = '{128, 0,  0, 1, 1, 0, 0, 1};

        resb = 1'b0; pix_en = 1'b0; interlace = 1'b0;
        wr = 1'b0; waddr = '0; wdata = '0;
        #12;
        chk_reset("rst0");

        // default-parameter instance: two lines
        step();
        resb = 1'b1;
        pix_en = 1'b1;
        for (int i = 1; i <= 1024; i++) begin
            step();
            p = (i - 1) % 512;
            chk("def_hs", d_hsync_n, !(p >= 470 && p < 510));
            chk("def_vs", d_vsync_n, 0);
            chk("def_de", d_de, 0);
            chk("def_bn", d_blank_n, 0);
            if (i == 512) begin
                chk("def_l1_h", d_hcnt, 0);
                chk("def_l1_v", d_vcnt, 1);
            end
        end
        chk("def_l2_v", d_vcnt, 2);

        resb = 1'b0;
        #2;
        chk_reset("rst1");
        resb = 1'b1;
        edges = 0;

        foreach (tbl[k]) begin
            while (edges < tbl[k].n) begin
                step();
                edges++;
            end
            chk("tbl_hcnt", hcnt, tbl[k].h);
            chk("tbl_vcnt", vcnt, tbl[k].v);
            chk("tbl_hs", hsync_n, tbl[k].hs);
            chk("tbl_vs", vsync_n, tbl[k].vs);
            chk("tbl_de", de, tbl[k].de);
            chk("tbl_bn", blank_n, tbl[k].bn);
            chk("tbl_fs", frame_start, tbl[k].fs);
        end
        step();
        chk("f2_hcnt", hcnt, 1);
        chk("f2_vs", vsync_n, 0);

        // interlace, sampled at the end of frame 2
        interlace = 1'b1;
        wait_fs(300, n);
        chk("il_gap0", n, 127);
        chk("il_field1", field, 1);
        chk("il_vcnt0", vcnt, 0);
        run(8);
        chk("odd_vs_pre", vsync_n, 1);
        run(1);
        chk("odd_vs_fall", vsync_n, 0);
        chk("odd_vs_fall_h", hcnt, 9);
        run(31);
        chk("odd_vs_hold", vsync_n, 0);
        run(1);
        chk("odd_vs_rise", vsync_n, 1);
        chk("odd_vs_rise_v", vcnt, 2);
        wait_fs(300, n);
        chk("odd_len", n + 41, 144);
        chk("il_field0", field, 0);
        wait_fs(300, n);
        chk("even_len", n, 128);
        chk("il_field1b", field, 1);
        interlace = 1'b0;
        wait_fs(300, n);
        chk("odd_len2", n, 144);
        chk("prog_field", field, 0);
        wait_fs(300, n);
        chk("prog_len", n, 128);
        chk("prog_field2", field, 0);

        // H_LAST reprogramming mid-frame and on the wrap cycle
        run(20);
        wreg(0, 9);
        wait_fs(300, n);
        chk("hl_cur_len", n + 21, 128);
        wait_hv(9, 7, 200, c1);
        wr = 1'b1; waddr = 4'd0; wdata = 16'd13;
        step();
        wr = 1'b0;
        chk("hl_new_len", c1 + 1, 80);
        chk("hl_wrap_fs", frame_start, 1);
        wait_fs(300, n);
        chk("hl_wrap_len", n, 80);
        wait_fs(300, n);
        chk("hl_late_len", n, 112);

        // pixel enable every second clock, 14-pixel lines
        en = 0; z0 = -1; z1 = -1; exp_hs = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            pix_en = (k % 2 == 1);
            if (pix_en) exp_hs = !((en % 14) >= 12 && (en % 14) < 15);
            step();
            if (pix_en) en++;
            chk("pe_hcnt", hcnt, en % 14);
            chk("pe_vcnt", vcnt, en / 14);
            chk("pe_hs", hsync_n, exp_hs);
            chk("pe_fs", frame_start, 0);
            if (pix_en && hcnt == 0) begin
                if (z0 < 0) z0 = k;
                else if (z1 < 0) z1 = k;
            end
        end
        chk("pe_period", z1 - z0, 28);
        pix_en = 1'b1;

        // degenerate windows: start == end, start > end
        wreg(3, 300);
        wreg(4, 300);
        wreg(1, 500);
        wreg(2, 10);
        wait_fs(300, n);
        for (int k = 0; k < 112; k++) begin
            step();
            chk("nw_hs", hsync_n, 1);
            chk("nw_de", de, 0);
        end

        // asynchronous reset mid-frame
        wait_hv(0, 5, 200, c1);
        #2;
        resb = 1'b0;
        #1;
        chk_reset("rst2");
        #2;
        resb = 1'b1;
        step();
        chk("post_rst_h", hcnt, 1);
        chk("post_rst_vs", vsync_n, 0);
        wait_fs(300, n);
        chk("post_rst_len", n, 127);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
